// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and constants for the fetch/decode front end.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

  typedef logic [31:0] word_t;

  localparam word_t INSTR_NOP = 32'h0000_0013;
  localparam int    ILEN      = 32;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_if
//  Description : Memory, redirect and decode-side signals of the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface instruction_fetch_if;
  import riscv_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  word_t imem_req_addr;
  logic  imem_rsp_valid;
  word_t imem_rsp_data;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  if_valid;
  logic  if_ready;
  word_t if_instr;
  word_t if_pc;

  // master = fetch stage, slave = its environment (memory, execute, decode)
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, if_ready
  );

endinterface : instruction_fetch_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO with flush; push while full allowed with pop.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  wire                     clk,
  input  wire                     rst_n,
  input  wire                     flush_i,
  input  wire                     push_i,
  input  wire [WIDTH-1:0]         push_data_i,
  input  wire                     pop_i,
  output logic [WIDTH-1:0]        head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]    count_q, count_d;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (c_aw+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_aw'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_aw'(1);
      count_d = count_q + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop);
    end
  end

  // Storage is reset so that an empty buffer presents all-zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (w_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : PC, credit-limited imem reads, buffered words and redirect flush.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 2
) (
  input wire                  clk,
  input wire                  rst_n,
  instruction_fetch_if.master bus
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

  word_t           pc_q, pc_d;
  logic            run_q;
  logic [c_cw-1:0] outstanding_q, outstanding_d;
  logic [c_cw-1:0] drop_q, drop_d;
  word_t           tag_q [FIFO_DEPTH];
  logic [c_aw-1:0] tag_wr_q, tag_wr_d;
  logic [c_aw-1:0] tag_rd_q, tag_rd_d;

  logic [2*ILEN-1:0] w_head;
  logic [c_cw-1:0]   w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [c_cw:0]     w_inflight;
  logic              w_credit;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_rsp;
  logic              w_keep;
  logic              w_push;
  logic              w_pop;

  assign w_rsp       = bus.imem_rsp_valid;
  assign w_inflight  = {1'b0, outstanding_q} + {1'b0, w_fifo_count};
  assign w_credit    = (w_inflight < (c_cw+1)'(FIFO_DEPTH));
  // run_q holds off the first request until the first clock after reset release
  assign w_req_valid = run_q && !bus.redirect_valid && w_credit && (drop_q == '0);
  assign w_accept    = w_req_valid && bus.imem_req_ready;
  assign w_keep      = w_rsp && !bus.redirect_valid && (drop_q == '0);
  assign w_pop       = !w_fifo_empty && bus.if_ready;
  assign w_push      = w_keep && (!w_fifo_full || w_pop);

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + c_cw'(w_accept) - c_cw'(w_rsp);
    drop_d        = drop_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      drop_d   = outstanding_q - c_cw'(w_rsp);
      tag_wr_d = '0;
      tag_rd_d = '0;
    end else begin
      if (w_accept) begin
        pc_d     = pc_q + 32'd4;
        tag_wr_d = tag_wr_q + c_aw'(1);
      end
      if (w_rsp) begin
        if (drop_q != '0) drop_d   = drop_q - c_cw'(1);
        else              tag_rd_d = tag_rd_q + c_aw'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      run_q         <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      pc_q          <= pc_d;
      run_q         <= 1'b1;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      if (w_accept) tag_q[tag_wr_q] <= pc_q;
    end
  end

  fetch_fifo #(
    .WIDTH (2*ILEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.redirect_valid),
    .push_i      (w_push),
    .push_data_i ({tag_q[tag_rd_q], bus.imem_rsp_data}),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .count_o     (w_fifo_count)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = !w_fifo_empty;
  assign bus.if_pc          = w_head[2*ILEN-1:ILEN];
  assign bus.if_instr       = w_head[ILEN-1:0];

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Directed bench for instruction_fetch with an in-order imem model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat    = 1;
  int   acc_cnt = 0;
  int   cyc     = 0;
  logic saw_400 = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t pq[$];

  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // In-order memory: response valid lat cycles after accept, one per cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete();
      cyc = 0;
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
    end else begin
      if (bus.imem_rsp_valid && pq.size() > 0) void'(pq.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready)
        pq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      if (pq.size() > 0 && pq[0].due <= cyc + 1) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= img(pq[0].addr);
      end else begin
        bus.imem_rsp_valid <= 1'b0;
      end
      cyc = cyc + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt = 0;
    else if (bus.imem_req_valid && bus.imem_req_ready) begin
      acc_cnt = acc_cnt + 1;
      if (bus.imem_req_addr == 32'h0000_0400) saw_400 = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    bus.if_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int n, input logic [31:0] start);
    logic [31:0] exp = start;
    int got = 0;
    int budget = 0;
    while (got < n && budget < 100) begin
      if (bus.if_valid && bus.if_ready) begin
        checks++;
        if (bus.if_pc !== exp) begin
          errors++;
          $display("FAIL %s_pc: got %h expected %h", tag, bus.if_pc, exp);
        end
        checks++;
        if (bus.if_instr !== img(exp)) begin
          errors++;
          $display("FAIL %s_instr: got %h expected %h", tag, bus.if_instr, img(exp));
        end
        exp = exp + 32'd4;
        got++;
      end
      @(negedge clk);
      budget++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words expected %0d", tag, got, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL %s_if_valid: got %b expected 0", tag, bus.if_valid);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL %s_req_valid: got %b expected 0", tag, bus.imem_req_valid);
    end
    checks++;
    if (bus.if_instr !== 32'h0) begin
      errors++; $display("FAIL %s_if_instr: got %h expected 00000000", tag, bus.if_instr);
    end
    checks++;
    if (bus.if_pc !== 32'h0) begin
      errors++; $display("FAIL %s_if_pc: got %h expected 00000000", tag, bus.if_pc);
    end
    checks++;
    if (bus.imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL %s_req_addr: got %h expected 00000000", tag, bus.imem_req_addr);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    lat = 1;
    bus.if_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.if_valid && n < 10);
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL first_valid_latency: got %0d expected 3", n);
    end
    collect("stream", 8, 32'h0);
  endtask

  task automatic test_backpressure();
    lat = 1;
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
          errors++;
          $display("FAIL hold_head: got valid=%b pc=%h expected valid=1 pc=00000000",
                   bus.if_valid, bus.if_pc);
        end
      end
    end
    checks++;
    if (acc_cnt != 2) begin
      errors++; $display("FAIL bp_accepts: got %0d expected 2", acc_cnt);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL bp_req_valid: got %b expected 0", bus.imem_req_valid);
    end
    checks++;
    if (bus.if_instr !== img(32'h0)) begin
      errors++; $display("FAIL bp_instr: got %h expected %h", bus.if_instr, img(32'h0));
    end
    bus.if_ready = 1'b1;
    collect("bp_resume", 6, 32'h0);
  endtask

  task automatic test_redirect_drop();
    int budget = 0;
    lat = 3;
    do_reset(1'b1);
    while (acc_cnt < 2 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (acc_cnt != 2) begin
      errors++; $display("FAIL rd_inflight: got %0d expected 2", acc_cnt);
    end
    redirect(32'h0000_0100);
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL rd_if_valid: got %b expected 0", bus.if_valid);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rd_drop_hold: got %b expected 0", bus.imem_req_valid);
    end
    checks++;
    if (bus.imem_req_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL rd_addr: got %h expected 00000100", bus.imem_req_addr);
    end
    collect("rd_new", 2, 32'h0000_0100);
  endtask

  task automatic test_unaligned();
    redirect(32'h0000_0203);
    checks++;
    if (bus.imem_req_addr !== 32'h0000_0200) begin
      errors++; $display("FAIL align_addr: got %h expected 00000200", bus.imem_req_addr);
    end
    collect("align", 2, 32'h0000_0200);
  endtask

  task automatic test_back_to_back();
    int budget = 0;
    lat = 1;
    redirect(32'h0000_0300);
    collect("settle", 2, 32'h0000_0300);
    while (!(bus.imem_rsp_valid && bus.if_valid && bus.if_ready) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (!(bus.imem_rsp_valid && bus.if_valid)) begin
      errors++; $display("FAIL collide_setup: got rsp=%b valid=%b expected 1 1",
                         bus.imem_rsp_valid, bus.if_valid);
    end
    saw_400 = 1'b0;
    redirect(32'h0000_0400);
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL collide_if_valid: got %b expected 0", bus.if_valid);
    end
    redirect(32'h0000_0500);
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_if_valid: got %b expected 0", bus.if_valid);
    end
    checks++;
    if (bus.imem_req_addr !== 32'h0000_0500) begin
      errors++; $display("FAIL b2b_addr: got %h expected 00000500", bus.imem_req_addr);
    end
    collect("b2b", 2, 32'h0000_0500);
    checks++;
    if (saw_400 !== 1'b0) begin
      errors++; $display("FAIL b2b_stale_fetch: got %b expected 0", saw_400);
    end
  endtask

  task automatic test_wrap_and_reset();
    int budget = 0;
    redirect(32'hFFFF_FFFC);
    checks++;
    if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: got %h expected fffffffc", bus.imem_req_addr);
    end
    collect("wrap", 3, 32'hFFFF_FFFC);
    while (!bus.if_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (bus.if_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_setup: got %b expected 1", bus.if_valid);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    collect("restart", 2, 32'h0);
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect_drop();
    test_unaligned();
    test_back_to_back();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
